toggle_event_receiver: RTL and testbench
========================================

Name: toggle_event_receiver

Overview:
- Destination-domain half of a multi-channel toggle-based event crossing.
- Each channel receives a level that toggles once per source event. The block synchronises it into aclk, detects each edge, and emits a one-cycle pulse.
- Each channel also queues events in a saturating pending counter, drained via a valid/ready handshake, with a sticky overflow flag.
- Sits at the consumer boundary of any CDC path that carries events as toggles.

Parameters:
- NB_CH, 4, number of independent toggle channels (>=1).
- SYNC_STAGES, 2, flops per synchroniser chain (>=2).
- CNT_W, 4, width of the per-channel pending-event counter; max count 2^CNT_W-1.

Ports:
- aclk  in  1  destination clock.
- arstn  in  1  asynchronous active-low reset.
- tgl_i  in  NB_CH  asynchronous toggle inputs, one per channel.
- pulse_o  out  NB_CH  one-cycle pulse per detected toggle edge.
- evt_valid_o  out  NB_CH  channel has at least one pending event.
- evt_ready_i  in  NB_CH  consumer pops one event when valid&ready.
- evt_cnt_o  out  NB_CH*CNT_W  pending count; channel c occupies bits [c*CNT_W +: CNT_W].
- ovf_o  out  NB_CH  sticky overflow flag per channel.
- ovf_clr_i  in  1  clears all ovf_o bits.
- ready_o  out  1  high once the startup mask has expired.

Behaviour:
- Reset state (arstn low, asynchronous): all sync flops, edge-history flops, counters, ovf_o, pulse_o, evt_valid_o and ready_o are 0. The startup mask counter is loaded with SYNC_STAGES+1.
- Synchroniser and edge detect:
  - Per channel, tgl_i passes through SYNC_STAGES flops, then through one history flop.
  - edge = last_stage XOR history.
  - tgl_i changing before edge E0 gives pulse_o high for exactly the cycle E0+SYNC_STAGES-1 .. E0+SYNC_STAGES.
  - Back-to-back toggles held >=1 cycle each produce one pulse each.
- Startup mask:
  - After reset release, edges are suppressed for SYNC_STAGES+1 cycles, so a tgl_i already high at reset produces no event.
  - ready_o rises on the cycle the mask counter reaches 0 and stays high until the next reset.
  - Edges occurring while masked are discarded: no pulse, no count change.
- Pending counter, per channel, evaluated each cycle with pop = evt_valid_o & evt_ready_i:
  - edge & !pop: cnt+1.
  - !edge & pop: cnt-1.
  - edge & pop: cnt unchanged.
  - neither: hold.
  - Saturation: edge & !pop with cnt = 2^CNT_W-1 leaves cnt unchanged and sets ovf_o the next cycle. pulse_o still fires.
  - evt_valid_o = (cnt != 0), driven from registers. Popping at cnt = 0 is impossible because valid is low.
- Overflow flag:
  - ovf_o is set on saturation overflow; ovf_clr_i clears it the next cycle.
  - A simultaneous set and clear on the same channel leaves ovf_o = 1 (set wins).
- Reset mid-operation discards all pending counts and overflow state, and re-arms the startup mask.
- Channels are fully independent; no arbitration between them.

Optional Feature:
- Macro: TOGGLE_EVENT_RECEIVER_PULSE_REG_EN.
- Defined: pulse_o is taken from an additional register stage, adding 1 cycle of latency (pulse in cycle E0+SYNC_STAGES .. E0+SYNC_STAGES+1) and making it glitch-free for driving other logic. Counter timing is unchanged.
- Undefined: pulse_o is the combinational XOR of the two flops, with latency as stated in Behaviour.

Decomposition:
- Package toggle_rx_pkg holds:
  - constant SYNC_STAGES_MIN = 2.
  - default values for NB_CH, SYNC_STAGES and CNT_W.
  - localparam helper CNT_MAX(CNT_W) = 2^CNT_W-1.
- Sub-module sync_bit_chain: a single-bit, SYNC_STAGES-deep synchroniser with async active-low reset. It is instantiated NB_CH times and is also reusable elsewhere.
- Edge detection, startup mask, counters and overflow logic stay in the top module, inside a generate loop per channel.

Test Plan:
- Reset with tgl_i = 4'b0101, release, hold inputs:
  - pulse_o stays 0 throughout.
  - all counts stay 0.
  - ready_o goes high 3 cycles after release (SYNC_STAGES = 2).
- After ready_o, toggle tgl_i[0] once, evt_ready_i = 0:
  - pulse_o[0] is high for 1 cycle, 2 cycles after sampling.
  - evt_cnt_o[0] = 1 and evt_valid_o[0] = 1.
  - the macro build shows the pulse 1 cycle later.
- Toggle ch1 20 times, one cycle apart, with ready low (CNT_W = 4):
  - count saturates at 15.
  - ovf_o[1] = 1.
  - 20 pulses are observed.
  - assert ovf_clr_i for 1 cycle: ovf_o[1] = 0.
- Hold evt_ready_i[2] = 1 while toggling ch2 every cycle: count stays <= 1 and every event is popped exactly once (pop total = 8 for 8 toggles).
- Assert ovf_clr_i in the same cycle that ch3 overflows: ovf_o[3] remains 1.
- Assert arstn low mid-burst with cnt[0] = 7: all outputs are 0 immediately, and after release no event is generated until ready_o is high.

Source files
------------

// File: rtl/toggle_rx_pkg.sv
// Shared constants, defaults and helpers for the toggle event receiver.
package toggle_rx_pkg;

  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned NB_CH_DEFAULT       = 4;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned CNT_W_DEFAULT       = 4;

  // Per-channel pending-counter action for one cycle.
  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec,
    CntSat
  } cnt_op_e;

  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_bit_chain.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module sync_bit_chain
  import toggle_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  // Never build a chain shorter than the metastability floor.
  localparam int unsigned Stages = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Multi-channel toggle-to-pulse receiver with pending-event counters and sticky overflow.
// Define TOGGLE_EVENT_RECEIVER_PULSE_REG_EN to register pulse_o (one extra cycle of latency).
module toggle_event_receiver
  import toggle_rx_pkg::*;
#(
  parameter int unsigned NB_CH       = NB_CH_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [NB_CH-1:0]       tgl_i,
  output logic [NB_CH-1:0]       pulse_o,
  output logic [NB_CH-1:0]       evt_valid_o,
  input  logic [NB_CH-1:0]       evt_ready_i,
  output logic [NB_CH*CNT_W-1:0] evt_cnt_o,
  output logic [NB_CH-1:0]       ovf_o,
  input  logic                   ovf_clr_i,
  output logic                   ready_o
);

  localparam int unsigned      MaskW    = $clog2(SYNC_STAGES + 2);
  localparam logic [MaskW-1:0] MaskInit = MaskW'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(cnt_max(CNT_W));

  // Startup mask: hides edges caused by the chains settling to the input level after reset.
  logic [MaskW-1:0] mask_q;
  logic [MaskW-1:0] mask_d;
  logic             mask_done;

  always_comb begin
    mask_done = (mask_q == '0);
    mask_d    = mask_q;
    if (!mask_done) begin
      mask_d = mask_q - MaskW'(1);
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      mask_q <= MaskInit;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign ready_o = mask_done;

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch
    logic             sync_out;
    logic             hist_q;
    logic             hist_d;
    logic             edge_raw;
    logic             edge_v;
    logic             pop;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             ovf_set;
    cnt_op_e          cnt_op;

    sync_bit_chain #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (aclk),
      .rst_ni(arstn),
      .d_i   (tgl_i[c]),
      .q_o   (sync_out)
    );

    always_comb begin
      hist_d   = sync_out;
      edge_raw = sync_out ^ hist_q;
      edge_v   = edge_raw & mask_done;
      pop      = (cnt_q != '0) & evt_ready_i[c];

      cnt_op = CntHold;
      if (edge_v && !pop) begin
        cnt_op = (cnt_q == CntMax) ? CntSat : CntInc;
      end else if (!edge_v && pop) begin
        cnt_op = CntDec;
      end

      cnt_d   = cnt_q;
      ovf_set = 1'b0;
      unique case (cnt_op)
        CntInc:  cnt_d = cnt_q + CNT_W'(1);
        CntDec:  cnt_d = cnt_q - CNT_W'(1);
        CntSat:  ovf_set = 1'b1;
        default: cnt_d = cnt_q;
      endcase

      // Set has priority over clear so an overflow in the clearing cycle is never lost.
      ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        hist_q <= 1'b0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        hist_q <= hist_d;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
      end
    end

`ifdef TOGGLE_EVENT_RECEIVER_PULSE_REG_EN
    logic pulse_q;
    logic pulse_d;

    always_comb begin
      pulse_d = edge_v;
    end

    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= pulse_d;
      end
    end

    assign pulse_o[c] = pulse_q;
`else
    assign pulse_o[c] = edge_v;
`endif

    assign evt_valid_o[c]              = (cnt_q != '0);
    assign evt_cnt_o[c*CNT_W +: CNT_W] = cnt_q;
    assign ovf_o[c]                    = ovf_q;
  end

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Scoreboard bench for toggle_event_receiver: directed toggles, monitor-checked pulses.
module tb_toggle_event_receiver;

  localparam int unsigned NB_CH       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 4;
`ifdef TOGGLE_EVENT_RECEIVER_PULSE_REG_EN
  localparam int PLAT = SYNC_STAGES + 1;
`else
  localparam int PLAT = SYNC_STAGES;
`endif

  logic                   aclk = 1'b0;
  logic                   arstn;
  logic [NB_CH-1:0]       tgl;
  logic [NB_CH-1:0]       pulse;
  logic [NB_CH-1:0]       valid;
  logic [NB_CH-1:0]       rdy;
  logic [NB_CH*CNT_W-1:0] cnt;
  logic [NB_CH-1:0]       ovf;
  logic                   clr;
  logic                   ready;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_pass   = 0;
  int   n_total  = 0;
  int   pulses[NB_CH];
  int   pops[NB_CH];
  int   max_cnt2 = 0;

  toggle_event_receiver #(
    .NB_CH      (NB_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .aclk       (aclk),
    .arstn      (arstn),
    .tgl_i      (tgl),
    .pulse_o    (pulse),
    .evt_valid_o(valid),
    .evt_ready_i(rdy),
    .evt_cnt_o  (cnt),
    .ovf_o      (ovf),
    .ovf_clr_i  (clr),
    .ready_o    (ready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic toggle(input int ch);
    exp_t e;
    tgl[ch] = ~tgl[ch];
    e.ch    = ch;
    e.cyc   = cyc + PLAT;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed pulse must match the oldest expected one.
  always @(negedge aclk) begin
    for (int c = 0; c < NB_CH; c++) begin
      if (valid[c] && rdy[c]) pops[c]++;
      if (pulse[c]) begin
        pulses[c]++;
        if (exp_q.size() == 0) begin
          chk("pulse_unexpected", int'(pulse[c]), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_ch", c, e.ch);
          chk("pulse_cyc", cyc, e.cyc);
        end
      end
    end
    if (int'(cnt[11:8]) > max_cnt2) max_cnt2 = int'(cnt[11:8]);
  end

  initial begin
    for (int c = 0; c < NB_CH; c++) begin
      pulses[c] = 0;
      pops[c]   = 0;
    end
    arstn = 1'b1;
    tgl   = 4'b0101;
    rdy   = '0;
    clr   = 1'b0;
    #2 arstn = 1'b0;
    step(2);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ready", int'(ready), 0);

    // Release with inputs already high on ch0/ch2: no events, ready after 3 cycles.
    arstn = 1'b1;
    step(2);
    chk("ready_lo_2", int'(ready), 0);
    step(1);
    chk("ready_hi_3", int'(ready), 1);
    step(3);
    chk("cnt_after_mask", int'(cnt), 0);
    chk("valid_after_mask", int'(valid), 0);

    // Single toggle on ch0.
    toggle(0);
    step(5);
    chk("ch0_cnt", int'(cnt[3:0]), 1);
    chk("ch0_valid", int'(valid[0]), 1);
    chk("ch0_pulses", pulses[0], 1);

    // 20 back-to-back toggles on ch1 saturate the counter.
    for (int i = 0; i < 20; i++) begin
      toggle(1);
      step(1);
    end
    step(4);
    chk("ch1_cnt_sat", int'(cnt[7:4]), 15);
    chk("ch1_ovf", int'(ovf[1]), 1);
    chk("ch1_pulses", pulses[1], 20);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ch1_ovf_clr", int'(ovf[1]), 0);
    chk("ch1_cnt_hold", int'(cnt[7:4]), 15);

    // ch2 drained continuously while toggling every cycle.
    rdy[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      toggle(2);
      step(1);
    end
    step(4);
    rdy[2] = 1'b0;
    chk("ch2_pops", pops[2], 8);
    chk("ch2_max_le1", int'(max_cnt2 <= 1), 1);
    chk("ch2_cnt", int'(cnt[11:8]), 0);
    chk("ch2_pulses", pulses[2], 8);

    // ch3: overflow in the same cycle as a clear; set wins.
    for (int i = 0; i < 15; i++) begin
      toggle(3);
      step(1);
    end
    step(4);
    chk("ch3_cnt_full", int'(cnt[15:12]), 15);
    chk("ch3_ovf_pre", int'(ovf[3]), 0);
    toggle(3);
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ch3_ovf_set_wins", int'(ovf[3]), 1);
    chk("ch3_cnt_sat", int'(cnt[15:12]), 15);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ch3_ovf_clr", int'(ovf[3]), 0);

    // Bring ch0 to 7 pending, then reset in the middle of a burst.
    for (int i = 0; i < 6; i++) begin
      toggle(0);
      step(1);
    end
    step(4);
    chk("ch0_cnt7", int'(cnt[3:0]), 7);
    tgl[0] = ~tgl[0];
    step(1);
    tgl[0] = ~tgl[0];
    arstn  = 1'b0;
    #1;
    chk("mid_rst_pulse", int'(pulse), 0);
    chk("mid_rst_cnt", int'(cnt), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_ready", int'(ready), 0);
    step(1);
    tgl[0] = ~tgl[0];
    step(1);
    arstn  = 1'b1;
    tgl[0] = ~tgl[0];
    step(2);
    chk("re_ready_lo", int'(ready), 0);
    chk("re_cnt_masked", int'(cnt[3:0]), 0);
    step(1);
    chk("re_ready_hi", int'(ready), 1);
    step(3);
    chk("re_cnt_zero", int'(cnt), 0);
    chk("re_valid_zero", int'(valid), 0);
    chk("re_ch0_pulses", pulses[0], 7);
    toggle(0);
    step(5);
    chk("re_ch0_cnt", int'(cnt[3:0]), 1);

    step(5);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
